acumulador_monedas: RTL and testbench

ACUMULADOR_MONEDAS -- requirements
Module: acumulador_monedas

---
 rtl/acumulador_monedas.sv | 187 ++++++++++++++++++
 tb/tb_acumulador_monedas.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_monedas.sv
// Coin credit accumulator for a vending machine.
// Synchronizes three coin sensors (1, 2 and 5 units) and accumulates 4-bit
// credit. It handles sale acceptance with change, cancel/timeout refunds and
// a fixed-length dispense window.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   moneda_1/2/5              asynchronous coin-sensor levels
//   cancelar, aceptada        refund request, sale accept (synchronous levels)
//   precio[3:0]               price of the accepted product
//   Acumulador_Monedas[3:0]   current credit (registered)
//   moneda_rechazada          one-cycle pulse per cycle with rejected coin(s)
//   cambio[3:0]               change amount, held between pulses
//   cambio_valido             one-cycle pulse qualifying cambio
//   dispensando               high while the product is dispensed
module acumulador_monedas #(
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned DISPENSE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       moneda_1,
  input  logic       moneda_2,
  input  logic       moneda_5,
  input  logic       cancelar,
  input  logic       aceptada,
  input  logic [3:0] precio,
  output logic [3:0] Acumulador_Monedas,
  output logic       moneda_rechazada,
  output logic [3:0] cambio,
  output logic       cambio_valido,
  output logic       dispensando
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > DISPENSE_CYCLES) ?
                                    TIMEOUT_CYCLES : DISPENSE_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned NCOIN   = 3;

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE} state_t;

  state_t           state_q, state_d;
  logic [NCOIN-1:0] sync1_q, sync1_d;
  logic [NCOIN-1:0] sync2_q, sync2_d;
  logic [NCOIN-1:0] prev_q, prev_d;
  logic [NCOIN-1:0] armed_q, armed_d;
  logic [1:0]       warm_q, warm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       credit_q, credit_d;
  logic [3:0]       cambio_q, cambio_d;
  logic             cv_q, cv_d;
  logic             rej_q, rej_d;
  logic             disp_q, disp_d;

  logic [NCOIN-1:0] ev;
  logic             any_ev;
  logic             multi_ev;
  logic [2:0]       coin_val;
  logic [4:0]       sum;
  logic             warm_done;

  // Synchronizers, edge detection, coin selection and the main FSM.
  always_comb begin
    sync1_d = {moneda_5, moneda_2, moneda_1};
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    // A sensor must be seen low after reset before its rise counts, so a
    // coin held through reset release is ignored until it is reinserted.
    warm_done = (warm_q == 2'd2);
    warm_d    = warm_done ? warm_q : warm_q + 2'd1;
    armed_d   = armed_q | ({NCOIN{warm_done}} & ~sync2_q);

    ev       = sync2_q & ~prev_q & armed_q;
    any_ev   = |ev;
    multi_ev = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
    // Only the highest-value coin of a simultaneous group is considered.
    if (ev[2])      coin_val = 3'd5;
    else if (ev[1]) coin_val = 3'd2;
    else if (ev[0]) coin_val = 3'd1;
    else            coin_val = 3'd0;
    sum = {1'b0, credit_q} + {2'b00, coin_val};

    state_d  = state_q;
    credit_d = credit_q;
    cambio_d = cambio_q;
    cnt_d    = cnt_q;
    cv_d     = 1'b0;
    rej_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_ev) begin
          credit_d = {1'b0, coin_val};
          cnt_d    = '0;
          rej_d    = multi_ev;
          state_d  = S_CREDIT;
        end
      end
      S_CREDIT: begin
        if (aceptada && (credit_q >= precio)) begin
          cambio_d = credit_q - precio;
          cv_d     = 1'b1;
          credit_d = '0;
          cnt_d    = '0;
          rej_d    = any_ev;
          state_d  = S_DISPENSE;
        end else if (cancelar) begin
          cambio_d = credit_q;
          cv_d     = 1'b1;
          credit_d = '0;
          rej_d    = any_ev;
          state_d  = S_IDLE;
        end else if (any_ev && !sum[4]) begin
          credit_d = sum[3:0];
          cnt_d    = '0;
          rej_d    = multi_ev;
        end else begin
          // No accepted coin this cycle: an overflowing coin is rejected and
          // the cycle still counts towards the inactivity timeout.
          rej_d = any_ev;
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            cambio_d = credit_q;
            cv_d     = 1'b1;
            credit_d = '0;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DISPENSE: begin
        rej_d = any_ev;
        if (cnt_q == CW'(DISPENSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        credit_d = '0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase

    disp_d = (state_d == S_DISPENSE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      warm_q   <= '0;
      cnt_q    <= '0;
      credit_q <= '0;
      cambio_q <= '0;
      cv_q     <= 1'b0;
      rej_q    <= 1'b0;
      disp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      armed_q  <= armed_d;
      warm_q   <= warm_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      cambio_q <= cambio_d;
      cv_q     <= cv_d;
      rej_q    <= rej_d;
      disp_q   <= disp_d;
    end
  end

  assign Acumulador_Monedas = credit_q;
  assign cambio             = cambio_q;
  assign cambio_valido      = cv_q;
  assign moneda_rechazada   = rej_q;
  assign dispensando        = disp_q;

endmodule

// File: tb/tb_acumulador_monedas.sv
// Testbench for acumulador_monedas: directed vector table, random stimulus
// against a behavioural model, and hand-written multi-cycle sequences.
module tb_acumulador_monedas;

  localparam int unsigned TO = 20;
  localparam int unsigned DC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       moneda_1, moneda_2, moneda_5, cancelar, aceptada;
  logic [3:0] precio;
  logic [3:0] Acumulador_Monedas, cambio;
  logic       moneda_rechazada, cambio_valido, dispensando;

  acumulador_monedas #(.TIMEOUT_CYCLES(TO), .DISPENSE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .moneda_1(moneda_1), .moneda_2(moneda_2), .moneda_5(moneda_5),
    .cancelar(cancelar), .aceptada(aceptada), .precio(precio),
    .Acumulador_Monedas(Acumulador_Monedas),
    .moneda_rechazada(moneda_rechazada),
    .cambio(cambio), .cambio_valido(cambio_valido),
    .dispensando(dispensando)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       m1, m2, m5, can, acc;
    logic [3:0] pr;
    logic [3:0] cr;
    logic       rej, cv;
    logic [3:0] cb;
    logic       disp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic m1, logic m2, logic m5, logic can,
                              logic acc, logic [3:0] pr, logic [3:0] cr,
                              logic rej, logic cv, logic [3:0] cb, logic disp);
    vec_t v;
    v.m1 = m1; v.m2 = m2; v.m5 = m5; v.can = can; v.acc = acc; v.pr = pr;
    v.cr = cr; v.rej = rej; v.cv = cv; v.cb = cb; v.disp = disp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int cr, input int rej,
                         input int cv, input int cb, input int disp);
    chk({tag, ".credit"}, 8'(Acumulador_Monedas), 8'(cr));
    chk({tag, ".rej"},    8'(moneda_rechazada),   8'(rej));
    chk({tag, ".cv"},     8'(cambio_valido),      8'(cv));
    chk({tag, ".cambio"}, 8'(cambio),             8'(cb));
    chk({tag, ".disp"},   8'(dispensando),        8'(disp));
  endtask

  task automatic drive_idle();
    moneda_1 = 0; moneda_2 = 0; moneda_5 = 0;
    cancelar = 0; aceptada = 0; precio = 4'd0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    step();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic set_coin(input int idx, input logic v);
    case (idx)
      0: moneda_1 = v;
      1: moneda_2 = v;
      default: moneda_5 = v;
    endcase
  endtask

  // Sensor high for 3 edges (credit updates on the 3rd), then low one edge.
  task automatic coin_in(input int idx);
    set_coin(idx, 1'b1);
    repeat (3) step();
    set_coin(idx, 1'b0);
    step();
  endtask

  // Behavioural reference model.
  int m_cr, m_cb, m_mode, m_idle, m_dc;
  bit m_rej, m_cv;
  bit [2:0] d1, d2, d3;

  task automatic model_reset();
    m_cr = 0; m_cb = 0; m_mode = 0; m_idle = 0; m_dc = 0;
    m_rej = 0; m_cv = 0; d1 = '0; d2 = '0; d3 = '0;
  endtask

  task automatic model_edge(input bit [2:0] lv, input bit can, input bit acc,
                            input int pr);
    bit [2:0] evs;
    int n, best;
    evs = d2 & ~d3;
    d3 = d2; d2 = d1; d1 = lv;
    n = int'(evs[0]) + int'(evs[1]) + int'(evs[2]);
    best = evs[2] ? 5 : evs[1] ? 2 : evs[0] ? 1 : 0;
    m_rej = 0; m_cv = 0;
    if (m_mode == 0) begin
      if (n > 0) begin
        m_cr = best; m_mode = 1; m_idle = 0; m_rej = (n > 1);
      end
    end else if (m_mode == 1) begin
      if (acc && m_cr >= pr) begin
        m_cb = m_cr - pr; m_cv = 1; m_cr = 0; m_mode = 2; m_dc = 0;
        m_rej = (n > 0);
      end else if (can) begin
        m_cb = m_cr; m_cv = 1; m_cr = 0; m_mode = 0; m_rej = (n > 0);
      end else if (n > 0 && m_cr + best <= 15) begin
        m_cr = m_cr + best; m_idle = 0; m_rej = (n > 1);
      end else begin
        m_rej = (n > 0);
        m_idle++;
        if (m_idle == TO) begin
          m_cb = m_cr; m_cv = 1; m_cr = 0; m_mode = 0;
        end
      end
    end else begin
      m_rej = (n > 0);
      m_dc++;
      if (m_dc == DC) m_mode = 0;
    end
  endtask

  initial begin
    int n, disp_n, rej_n, cv_n;
    bit [2:0] lv;
    rst = 1'b1;
    drive_idle();

    // Directed table: coin latency, overflow, simultaneous coins, sale.
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 5,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 5,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 5,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 5,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 7,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 7,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 7,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 7,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 7,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 7,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 12,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 12,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 12,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 12,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 12,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 12,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 12,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 12,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 14,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 14,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,15, 14,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 14,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,14, 0,0,1,0,1));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      moneda_1 = tbl[i].m1; moneda_2 = tbl[i].m2; moneda_5 = tbl[i].m5;
      cancelar = tbl[i].can; aceptada = tbl[i].acc; precio = tbl[i].pr;
      step();
      chk_all($sformatf("vec%0d", i), int'(tbl[i].cr), int'(tbl[i].rej),
              int'(tbl[i].cv), int'(tbl[i].cb), int'(tbl[i].disp));
    end

    // Random stimulus against the model.
    do_reset();
    model_reset();
    lv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) lv[b] = ~lv[b];
      {moneda_5, moneda_2, moneda_1} = lv;
      cancelar = ($urandom_range(0, 15) == 0);
      aceptada = ($urandom_range(0, 5) == 0);
      precio   = 4'($urandom_range(0, 15));
      step();
      model_edge(lv, cancelar, aceptada, int'(precio));
      chk_all("rand", m_cr, int'(m_rej), int'(m_cv), m_cb, (m_mode == 2) ? 1 : 0);
    end

    // Cancel refund; cambio held; cancelar ignored in IDLE.
    do_reset();
    coin_in(2);
    coin_in(0);
    chk("cancel.credit6", 8'(Acumulador_Monedas), 8'd6);
    cancelar = 1; step(); cancelar = 0;
    chk_all("cancel", 0, 0, 1, 6, 0);
    step();
    chk_all("cancel.after", 0, 0, 0, 6, 0);
    cancelar = 1; step(); cancelar = 0;
    chk_all("cancel.idle", 0, 0, 0, 6, 0);

    // Inactivity timeout refund.
    do_reset();
    coin_in(1);
    coin_in(0);
    chk("timeout.credit3", 8'(Acumulador_Monedas), 8'd3);
    n = 0;
    while (cambio_valido !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("timeout.cycles", 8'(n), 8'(TO - 1));
    chk("timeout.cambio", 8'(cambio), 8'd3);
    chk("timeout.credit", 8'(Acumulador_Monedas), 8'd0);

    // Sale with change, dispense window, coin rejected while dispensing.
    do_reset();
    coin_in(2);
    coin_in(1);
    chk("sale.credit7", 8'(Acumulador_Monedas), 8'd7);
    precio = 4'd4; aceptada = 1; step(); aceptada = 0;
    chk_all("sale", 0, 0, 1, 3, 1);
    moneda_1 = 1;
    disp_n = 1; rej_n = 0; cv_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) moneda_1 = 0;
      step();
      if (dispensando) disp_n++;
      if (moneda_rechazada) rej_n++;
      if (cambio_valido) cv_n++;
    end
    chk("sale.disp_cycles", 8'(disp_n), 8'(DC));
    chk("sale.rej_pulses", 8'(rej_n), 8'd1);
    chk("sale.cv_extra", 8'(cv_n), 8'd0);
    chk("sale.credit_after", 8'(Acumulador_Monedas), 8'd0);

    // Reset during DISPENSE.
    do_reset();
    coin_in(2);
    precio = 4'd3; aceptada = 1; step(); aceptada = 0;
    chk("rstd.cambio2", 8'(cambio), 8'd2);
    step(); step();
    rst = 1; step();
    chk_all("rstd", 0, 0, 0, 0, 0);
    rst = 0;

    // Reset during CREDIT 9.
    do_reset();
    coin_in(2);
    coin_in(1);
    coin_in(1);
    chk("rstc.credit9", 8'(Acumulador_Monedas), 8'd9);
    rst = 1; step();
    chk_all("rstc", 0, 0, 0, 0, 0);
    rst = 0;

    // Coin held through reset release counts only after reinsertion.
    moneda_5 = 1;
    rst = 1; step(); step(); rst = 0;
    rej_n = 0; n = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (moneda_rechazada) rej_n++;
      if (Acumulador_Monedas != 4'd0) n++;
    end
    chk("hold.no_credit", 8'(n), 8'd0);
    chk("hold.no_rej", 8'(rej_n), 8'd0);
    moneda_5 = 0; step(); step();
    moneda_5 = 1; repeat (3) step();
    chk("hold.reinsert", 8'(Acumulador_Monedas), 8'd5);
    moneda_5 = 0; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
